// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, derived totals and the sync-generator output bundle.
package vga_timing_pkg;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic       line_end;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RST = '{row: 10'd0, col: 10'd0, hsync: 1'b1, vsync: 1'b1,
                                       video_on: 1'b0, frame_start: 1'b0, line_end: 1'b0};

  function automatic logic in_win(input logic [9:0] v, input int lo, input int n);
    return (v >= 10'(lo)) && (v < 10'(lo + n));
  endfunction
endpackage

// File: rtl/vga_sync_gen_mod_counter.sv
// mod_counter: enabled modulo-MOD counter with a one-cycle wrap pulse on its terminal count.
module mod_counter #(
  parameter int MOD = 800,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap_o = en_i && (cnt_q == W'(MOD - 1));
  assign cnt_d  = wrap_o ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o  = cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster counters with sync/blank decode.
// Define VGA_SYNC_PIPE_EN to register all outputs (one extra cycle of latency).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic       clk_25,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] s_pixel_row,
  output logic [9:0] s_pixel_col,
  output logic       frame_start,
  output logic       line_end
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  logic [9:0] col, row;
  logic       h_wrap, unused_v_wrap;
  vga_out_t   out_d, out;

  mod_counter #(.MOD(H_TOTAL), .W(10)) u_hcnt (
    .clk(clk_25), .rst_n(rst_n), .en_i(1'b1), .cnt_o(col), .wrap_o(h_wrap)
  );
  mod_counter #(.MOD(V_TOTAL), .W(10)) u_vcnt (
    .clk(clk_25), .rst_n(rst_n), .en_i(h_wrap), .cnt_o(row), .wrap_o(unused_v_wrap)
  );

  // Gating with rst_n keeps the combinational outputs at their idle values while reset is held.
  always_comb begin
    out_d.row         = row;
    out_d.col         = col;
    out_d.hsync       = !rst_n || !in_win(col, H_VISIBLE + H_FP, H_SYNC);
    out_d.vsync       = !rst_n || !in_win(row, V_VISIBLE + V_FP, V_SYNC);
    out_d.video_on    = rst_n && (col < 10'(H_VISIBLE)) && (row < 10'(V_VISIBLE));
    out_d.frame_start = rst_n && (col == '0) && (row == '0);
    out_d.line_end    = rst_n && h_wrap;
  end

`ifdef VGA_SYNC_PIPE_EN
  vga_out_t out_q;
  always_ff @(posedge clk_25 or negedge rst_n)
    if (!rst_n) out_q <= VGA_OUT_RST;
    else        out_q <= out_d;
  assign out = out_q;
`else
  assign out = out_d;
`endif

  assign s_pixel_row = out.row;
  assign s_pixel_col = out.col;
  assign hsync       = out.hsync;
  assign vsync       = out.vsync;
  assign video_on    = out.video_on;
  assign frame_start = out.frame_start;
  assign line_end    = out.line_end;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for a reduced-timing and a default-timing vga_sync_gen under random resets.
module tb_vga_sync_gen;
  localparam int SHV = 20, SHF = 4, SHS = 6, SHB = 5;
  localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;

  logic clk_25 = 1'b0;
  logic rst_n;
  logic       s_hs, s_vs, s_von, s_fs, s_le, d_hs, d_vs, d_von, d_fs, d_le;
  logic [9:0] s_row, s_col, d_row, d_col;

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic [49:0] q[$];

  always #5 clk_25 = ~clk_25;

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .clk_25(clk_25), .rst_n(rst_n), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .s_pixel_row(s_row), .s_pixel_col(s_col), .frame_start(s_fs), .line_end(s_le)
  );

  vga_sync_gen dut_d (
    .clk_25(clk_25), .rst_n(rst_n), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .s_pixel_row(d_row), .s_pixel_col(d_col), .frame_start(d_fs), .line_end(d_le)
  );

  localparam logic [24:0] RST_VAL = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // Raster position after n clocks of free running, straight from the timing rules.
  function automatic logic [24:0] raster(input int n, input int hv, input int hf, input int hs,
                                         input int hb, input int vv, input int vf, input int vs,
                                         input int vb);
    int ht, vt, col, row;
    logic h, v, von, fs, le;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    col = n % ht;
    row = (n / ht) % vt;
    h   = !(col >= hv + hf && col < hv + hf + hs);
    v   = !(row >= vv + vf && row < vv + vf + vs);
    von = col < hv && row < vv;
    fs  = (n % (ht * vt)) == 0;
    le  = col == ht - 1;
    return {10'(row), 10'(col), h, v, von, fs, le};
  endfunction

  function automatic logic [49:0] expected();
    int n;
    if (!rst_n) return {RST_VAL, RST_VAL};
`ifdef VGA_SYNC_PIPE_EN
    if (t == 0) return {RST_VAL, RST_VAL};
    n = t - 1;
`else
    n = t;
`endif
    return {raster(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB),
            raster(n, 640, 16, 96, 48, 480, 10, 2, 33)};
  endfunction

  // t counts rising edges seen with reset released; reset changes land mid-cycle, away from edges.
  task automatic step(input bit do_assert, input bit do_release);
    @(posedge clk_25);
    if (rst_n) t++;
    #2;
    if (do_assert) begin
      rst_n = 1'b0;
      t = 0;
    end
    if (do_release) rst_n = 1'b1;
    q.push_back(expected());
  endtask

  initial begin
    logic [49:0] e;
    logic [24:0] a_s, a_d;
    forever begin
      @(negedge clk_25);
      if (q.size() > 0) begin
        e   = q.pop_front();
        a_s = {s_row, s_col, s_hs, s_vs, s_von, s_fs, s_le};
        a_d = {d_row, d_col, d_hs, d_vs, d_von, d_fs, d_le};
        checks += 2;
        if (a_s !== e[49:25]) begin
          errors++;
          $display("FAIL small_dut t=%0d rst_n=%0b got row=%0d col=%0d hs/vs/von/fs/le=%b want row=%0d col=%0d hs/vs/von/fs/le=%b",
                   t, rst_n, a_s[24:15], a_s[14:5], a_s[4:0], e[49:40], e[39:30], e[29:25]);
        end
        if (a_d !== e[24:0]) begin
          errors++;
          $display("FAIL default_dut t=%0d rst_n=%0b got row=%0d col=%0d hs/vs/von/fs/le=%b want row=%0d col=%0d hs/vs/von/fs/le=%b",
                   t, rst_n, a_d[24:15], a_d[14:5], a_d[4:0], e[24:15], e[14:5], e[4:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (2 * 595 + 900) step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(700, 20)) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat ($urandom_range(2, 0)) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    repeat (1300) step(1'b0, 1'b0);
    repeat (2) @(posedge clk_25);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
